// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding
// and default operand width.
package multiplicador_pkg;

    localparam int unsigned LARGURA_PADRAO = 32;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CALCULA = 2'b01,
        PRONTO  = 2'b10
    } estado_t;

endpackage

// File: rtl/somador_parcial.sv
// LARGURA-bit adder with carry out, used for the partial-product add of
// each shift-add step.
module somador_parcial #(
    parameter int LARGURA = 32
) (
    input  logic [LARGURA-1:0] a_i,
    input  logic [LARGURA-1:0] b_i,
    output logic [LARGURA-1:0] soma_o,
    output logic               carry_o
);

    assign {carry_o, soma_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/multiplicador_sequencial.sv
// Unsigned sequential multiplier: one shift-add step per clock, fixed
// latency of LARGURA cycles from an accepted start to the pronto pulse.
module multiplicador_sequencial
    import multiplicador_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic [LARGURA-1:0]   multiplicando,
    input  logic [LARGURA-1:0]   multiplicador,
    output logic [2*LARGURA-1:0] produto,
    output logic                 ocupado,
    output logic                 pronto
);

    localparam int CW = $clog2(LARGURA + 1);

    estado_t              estado_q, estado_d;
    logic [CW-1:0]        cont_q, cont_d;
    logic [LARGURA-1:0]   mcand_q, mcand_d;
    logic [2*LARGURA-1:0] acc_q, acc_d;
    logic [2*LARGURA-1:0] produto_q, produto_d;

    logic [LARGURA-1:0]   parcela;
    logic [LARGURA-1:0]   soma;
    logic                 carry;
    logic [2*LARGURA-1:0] passo;

    // Upper half accumulates partial sums; lower half holds the multiplier,
    // consumed one bit per step as the whole register shifts right.
    assign parcela = acc_q[0] ? mcand_q : '0;

    somador_parcial #(
        .LARGURA(LARGURA)
    ) u_somador (
        .a_i    (acc_q[2*LARGURA-1:LARGURA]),
        .b_i    (parcela),
        .soma_o (soma),
        .carry_o(carry)
    );

    assign passo = {carry, soma, acc_q[LARGURA-1:1]};

    always_comb begin
        estado_d  = estado_q;
        cont_d    = cont_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        produto_d = produto_q;
        case (estado_q)
            OCIOSO, PRONTO: begin
                if (iniciar) begin
                    mcand_d  = multiplicando;
                    acc_d    = {{LARGURA{1'b0}}, multiplicador};
                    cont_d   = CW'(LARGURA);
                    estado_d = CALCULA;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            CALCULA: begin
                acc_d  = passo;
                cont_d = cont_q - CW'(1);
                if (cont_q == CW'(1)) begin
                    produto_d = passo;
                    estado_d  = PRONTO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            cont_q    <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            produto_q <= '0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            produto_q <= produto_d;
        end
    end

    assign produto = produto_q;
    assign ocupado = (estado_q == CALCULA);
    assign pronto  = (estado_q == PRONTO);

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Directed bench for multiplicador_sequencial (LARGURA=32) with
// hand-computed products and latencies.
module tb_multiplicador_sequencial;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [63:0] produto;
    logic        ocupado;
    logic        pronto;

    int errors = 0;
    int checks = 0;
    int cycles;
    int busy;
    int npronto;
    logic [63:0] mid_prod;

    multiplicador_sequencial #(
        .LARGURA(32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .multiplicando(mcand),
        .multiplicador(mplier),
        .produto      (produto),
        .ocupado      (ocupado),
        .pronto       (pronto)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses iniciar for one edge; returns at the first falling edge after it.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        mcand   = a;
        mplier  = b;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // Counts edges until pronto; optionally injects a new start at edge 'inj'
    // and records produto at edge 16 to confirm it is held during CALCULA.
    task automatic wait_pronto(input int inj, output int cyc, output int bsy,
                               output logic [63:0] mid);
        cyc = 0;
        bsy = 0;
        mid = 'x;
        while (!pronto && cyc < 100) begin
            if (ocupado) bsy++;
            if (cyc == 16) mid = produto;
            if (inj >= 0 && cyc == inj) begin
                iniciar = 1'b1;
                mcand   = 32'd5;
                mplier  = 32'd5;
            end
            if (inj >= 0 && cyc == inj + 1) iniciar = 1'b0;
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic after_pronto(input string tag, input logic [63:0] exp);
        @(negedge clock);
        chk({tag, "_pulse_len"}, {63'd0, pronto}, 64'd0);
        chk({tag, "_idle"}, {63'd0, ocupado}, 64'd0);
        chk({tag, "_hold"}, produto, exp);
    endtask

    initial begin
        reset   = 1'b0;
        iniciar = 1'b0;
        mcand   = '0;
        mplier  = '0;
        #3;
        chk("rst_produto", produto, 64'd0);
        chk("rst_ocupado", {63'd0, ocupado}, 64'd0);
        chk("rst_pronto", {63'd0, pronto}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // 0x20000000 * 4
        start(32'h2000_0000, 32'h4);
        chk("t1_busy_start", {63'd0, ocupado}, 64'd1);
        wait_pronto(-1, cycles, busy, mid_prod);
        chk("t1_latency", 64'(cycles), 64'd32);
        chk("t1_produto", produto, 64'h0000_0000_8000_0000);
        after_pronto("t1", 64'h0000_0000_8000_0000);

        // zero operand
        start(32'h0, 32'h1234_5678);
        wait_pronto(-1, cycles, busy, mid_prod);
        chk("t2_latency", 64'(cycles), 64'd32);
        chk("t2_mid_hold", mid_prod, 64'h0000_0000_8000_0000);
        chk("t2_produto", produto, 64'd0);
        after_pronto("t2", 64'd0);

        // full scale
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_pronto(-1, cycles, busy, mid_prod);
        chk("t3_latency", 64'(cycles), 64'd32);
        chk("t3_busy_cycles", 64'(busy), 64'd32);
        chk("t3_produto", produto, 64'hFFFF_FFFE_0000_0001);
        after_pronto("t3", 64'hFFFF_FFFE_0000_0001);

        // restart attempt and operand change mid-calculation
        start(32'h1000, 32'h3);
        wait_pronto(10, cycles, busy, mid_prod);
        chk("t4_latency", 64'(cycles), 64'd32);
        chk("t4_mid_hold", mid_prod, 64'hFFFF_FFFE_0000_0001);
        chk("t4_produto", produto, 64'h3000);
        after_pronto("t4", 64'h3000);

        // asynchronous abort at cycle 15 of CALCULA
        start(32'd7, 32'd9);
        repeat (15) @(negedge clock);
        chk("t5_busy_before_abort", {63'd0, ocupado}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5_abort_produto", produto, 64'd0);
        chk("t5_abort_ocupado", {63'd0, ocupado}, 64'd0);
        chk("t5_abort_pronto", {63'd0, pronto}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        npronto = 0;
        repeat (40) begin
            @(negedge clock);
            if (pronto || ocupado) npronto++;
        end
        chk("t5_no_pronto", 64'(npronto), 64'd0);
        start(32'd3, 32'd5);
        wait_pronto(-1, cycles, busy, mid_prod);
        chk("t5_latency", 64'(cycles), 64'd32);
        chk("t5_produto", produto, 64'd15);
        after_pronto("t5", 64'd15);

        // back-to-back start from PRONTO
        start(32'd11, 32'd13);
        wait_pronto(-1, cycles, busy, mid_prod);
        chk("t6a_produto", produto, 64'd143);
        mcand   = 32'd7;
        mplier  = 32'd6;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        chk("t6_b2b_busy", {63'd0, ocupado}, 64'd1);
        chk("t6_b2b_no_pronto", {63'd0, pronto}, 64'd0);
        wait_pronto(-1, cycles, busy, mid_prod);
        chk("t6_latency", 64'(cycles), 64'd32);
        chk("t6_produto", produto, 64'd42);
        after_pronto("t6", 64'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
